// File: rtl/gpr_wbu_pkg.sv
// Shared constants and the writeback entry type for the GPR writeback unit.
package gpr_wbu_pkg;

  localparam int GPR_DATA_W = 32;
  localparam int GPR_ADDR_W = 5;
  localparam int WBQ_DEPTH  = 2;

  // One queued EXU result at the default widths.
  typedef struct packed {
    logic                  wen;
    logic [GPR_ADDR_W-1:0] rd;
    logic [GPR_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/gpr_wbu_queue.sv
// wb_queue: in-order circular FIFO. Every slot is exposed in age order
// (index 0 = head/oldest) so the top can compare all pending writes.
module wb_queue #(
  parameter int W     = 38,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             ents [DEPTH],
  output logic                     vlds [DEPTH]
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push && (count != FULL);
  assign pop_ok  = pop && (count != '0);

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are qualified by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Age-ordered view of the storage.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ents[i] = mem[rd_ptr + PW'(i)];
      vlds[i] = ((PW+1)'(i) < count);
    end
  end

endmodule

// File: rtl/gpr_wbu.sv
// gpr_wbu: writeback queue, register file, operand read ports and RAW hazard flag.
// Optional feature macro: GPR_BYPASS_EN (reads forward the youngest pending write,
// rd_hazard tied low).
module gpr_wbu
  import gpr_wbu_pkg::*;
#(
  parameter int DATA_W = GPR_DATA_W,
  parameter int ADDR_W = GPR_ADDR_W,
  parameter int DEPTH  = WBQ_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    exu_valid,
  output logic                    exu_ready,
  input  logic                    exu_wen,
  input  logic [ADDR_W-1:0]       exu_rd,
  input  logic [DATA_W-1:0]       exu_data,
  input  logic                    wb_stall,
  input  logic [ADDR_W-1:0]       raddr1,
  input  logic [ADDR_W-1:0]       raddr2,
  output logic [DATA_W-1:0]       gpr_rdata1,
  output logic [DATA_W-1:0]       gpr_rdata2,
  output logic                    rd_hazard,
  output logic                    wb_valid,
  output logic [ADDR_W-1:0]       wb_rd,
  output logic [DATA_W-1:0]       wb_data,
  output logic [$clog2(DEPTH):0]  q_count
);

  localparam int NREG = 1 << ADDR_W;
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic [DATA_W-1:0] rf [NREG];
  logic [EW-1:0]     q_ents [DEPTH];
  logic              q_vlds [DEPTH];
  entry_t            din;
  entry_t            head;
  logic              push;
  logic              pop;

  assign exu_ready = (q_count < FULL);
  assign push      = exu_valid && exu_ready;
  assign pop       = (q_count != '0) && !wb_stall;
  assign head      = entry_t'(q_ents[0]);

  // Pack the incoming result.
  always_comb begin
    din      = '0;
    din.wen  = exu_wen;
    din.rd   = exu_rd;
    din.data = exu_data;
  end

  wb_queue #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .count (q_count),
    .ents  (q_ents),
    .vlds  (q_vlds)
  );

  // Retire the head into the register file and register the retire report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= pop;
      if (pop) begin
        wb_rd   <= head.wen ? head.rd : '0;
        wb_data <= head.data;
        if (head.wen && (head.rd != '0)) rf[head.rd] <= head.data;
      end
    end
  end

  // Operand reads from committed state, then forwarding or hazard detection
  // over pending entries; scanning oldest to youngest lets the youngest win.
  always_comb begin
    entry_t e;
    logic   match;
    e          = '0;
    match      = 1'b0;
    rd_hazard  = 1'b0;
    gpr_rdata1 = (raddr1 == '0) ? '0 : rf[raddr1];
    gpr_rdata2 = (raddr2 == '0) ? '0 : rf[raddr2];
    for (int unsigned i = 0; i < DEPTH; i++) begin
      e     = entry_t'(q_ents[i]);
      match = q_vlds[i] && e.wen && (e.rd != '0);
`ifdef GPR_BYPASS_EN
      if (match && (e.rd == raddr1)) gpr_rdata1 = e.data;
      if (match && (e.rd == raddr2)) gpr_rdata2 = e.data;
`else
      if (match && ((e.rd == raddr1) || (e.rd == raddr2))) rd_hazard = 1'b1;
`endif
    end
  end

endmodule
